// File: rtl/reg_file_sb.sv
// reg_file_sb
//   Multi-port integer register file with an integrated write scoreboard.
//   Decode/issue reads source operands and reserves destination registers.
//   Writeback writes results and releases those reservations.
//   Register 0 is hardwired to zero and is never busy.
//
// Ports
//   clk         clock; all state changes on the rising edge
//   rst         asynchronous active-low reset
//   rs_addr     NUM_RS read addresses, port i at slice i
//   rs_data     NUM_RS read data words, combinational from rs_addr
//   rs_busy     per read port: the addressed register has a pending reservation
//   wr_en       per write port: write enable
//   wr_addr     per write port: destination register
//   wr_data     per write port: data to write
//   wr_release  per write port: together with wr_en, clears the busy bit of wr_addr
//   rsv_req     request to reserve rsv_addr
//   rsv_addr    register to reserve
//   rsv_ok      combinational grant: the register is free, or it is register 0
//   busy_cnt    registered count of busy registers
module reg_file_sb #(
  parameter int XLEN           = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_RS         = 2,
  parameter int NUM_WR         = 1,
  parameter int BYPASS         = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_RS*REG_ADDR_WIDTH-1:0] rs_addr,
  output logic [NUM_RS*XLEN-1:0]           rs_data,
  output logic [NUM_RS-1:0]                rs_busy,
  input  logic [NUM_WR-1:0]                wr_en,
  input  logic [NUM_WR*REG_ADDR_WIDTH-1:0] wr_addr,
  input  logic [NUM_WR*XLEN-1:0]           wr_data,
  input  logic [NUM_WR-1:0]                wr_release,
  input  logic                             rsv_req,
  input  logic [REG_ADDR_WIDTH-1:0]        rsv_addr,
  output logic                             rsv_ok,
  output logic [REG_ADDR_WIDTH:0]          busy_cnt
);

  localparam int NREG = 2 ** REG_ADDR_WIDTH;
  localparam int AW   = REG_ADDR_WIDTH;

  logic [XLEN-1:0]  regs [NREG];
  logic [NREG-1:0]  busy;
  logic [NREG-1:0]  busy_nxt;
  logic [AW:0]      busy_cnt_nxt;

  // Register array. Write ports are scanned in ascending order, so when
  // several ports hit the same address the highest index lands last and wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++) begin
        regs[r] <= '0;
      end
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && (wr_addr[j*AW +: AW] != '0)) begin
          regs[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
        end
      end
    end
  end

  // Read ports. The optional bypass forwards a same-cycle write to the
  // reader. It uses the same ascending scan as the array, so the bypass value
  // always matches what the array holds after the edge.
  always_comb begin
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rd;
    rs_data = '0;
    rs_busy = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      ra = rs_addr[i*AW +: AW];
      rd = regs[ra];
      if (BYPASS != 0) begin
        for (int j = 0; j < NUM_WR; j++) begin
          if (wr_en[j] && (wr_addr[j*AW +: AW] == ra)) begin
            rd = wr_data[j*XLEN +: XLEN];
          end
        end
      end
      if (ra == '0) begin
        rd = '0;
      end
      rs_data[i*XLEN +: XLEN] = rd;
      rs_busy[i]              = busy[ra];
    end
  end

  assign rsv_ok = rsv_req && ((rsv_addr == '0) || !busy[rsv_addr]);

  // Scoreboard next state. Releases are applied first. A reserve request to a
  // nonzero register then forces its bit to 1. There are three cases:
  //   - The register is free: the request is granted.
  //   - The register is busy and not released: the bit already stays 1.
  //   - The register is busy and released this cycle: the reserve wins.
  // In every case the result is busy, even though rsv_ok is low in the last two.
  always_comb begin
    busy_nxt = busy;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_en[j] && wr_release[j]) begin
        busy_nxt[wr_addr[j*AW +: AW]] = 1'b0;
      end
    end
    if (rsv_req && (rsv_addr != '0)) begin
      busy_nxt[rsv_addr] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  // busy_cnt is the popcount of the next busy vector. It is registered so
  // that it tracks busy exactly.
  always_comb begin
    busy_cnt_nxt = '0;
    for (int r = 0; r < NREG; r++) begin
      busy_cnt_nxt = busy_cnt_nxt + {{AW{1'b0}}, busy_nxt[r]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= busy_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb
//   Drives two instances of reg_file_sb with identical stimulus.
//   One instance has the bypass enabled and the other has it disabled.
//   A register-array / busy-vector model predicts what both instances must
//   show on every cycle. A set of literal expectations pins the model itself.
module tb_reg_file_sb;

  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NRS  = 2;
  localparam int NWR  = 2;
  localparam int NREG = 32;

  logic              clk;
  logic              rst;
  logic [NRS*AW-1:0] rs_addr;
  logic [NWR-1:0]    wr_en;
  logic [NWR*AW-1:0] wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic [NWR-1:0]    wr_release;
  logic              rsv_req;
  logic [AW-1:0]     rsv_addr;

  logic [NRS*XLEN-1:0] rs_data_b, rs_data_n;
  logic [NRS-1:0]      rs_busy_b, rs_busy_n;
  logic                rsv_ok_b, rsv_ok_n;
  logic [AW:0]         busy_cnt_b, busy_cnt_n;

  reg_file_sb #(.XLEN(XLEN), .REG_ADDR_WIDTH(AW), .NUM_RS(NRS), .NUM_WR(NWR), .BYPASS(1)) dut_b (
    .clk(clk), .rst(rst), .rs_addr(rs_addr), .rs_data(rs_data_b), .rs_busy(rs_busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_release(wr_release),
    .rsv_req(rsv_req), .rsv_addr(rsv_addr), .rsv_ok(rsv_ok_b), .busy_cnt(busy_cnt_b)
  );

  reg_file_sb #(.XLEN(XLEN), .REG_ADDR_WIDTH(AW), .NUM_RS(NRS), .NUM_WR(NWR), .BYPASS(0)) dut_n (
    .clk(clk), .rst(rst), .rs_addr(rs_addr), .rs_data(rs_data_n), .rs_busy(rs_busy_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_release(wr_release),
    .rsv_req(rsv_req), .rsv_addr(rsv_addr), .rsv_ok(rsv_ok_n), .busy_cnt(busy_cnt_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, got, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  logic [XLEN-1:0] m_regs [NREG];
  bit   [NREG-1:0] m_busy;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++) m_regs[r] = '0;
      m_busy = '0;
    end else begin
      for (int j = 0; j < NWR; j++)
        if (wr_en[j] && wr_addr[j*AW +: AW] != 0) m_regs[wr_addr[j*AW +: AW]] = wr_data[j*XLEN +: XLEN];
      for (int j = 0; j < NWR; j++)
        if (wr_en[j] && wr_release[j]) m_busy[wr_addr[j*AW +: AW]] = 1'b0;
      if (rsv_req && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
    end
  end

  function automatic logic [XLEN-1:0] exp_read(input logic [AW-1:0] a, input bit byp);
    logic [XLEN-1:0] v;
    if (a == 0) return '0;
    v = m_regs[a];
    if (byp)
      for (int j = 0; j < NWR; j++)
        if (wr_en[j] && wr_addr[j*AW +: AW] == a) v = wr_data[j*XLEN +: XLEN];
    return v;
  endfunction

  function automatic int exp_cnt();
    int c = 0;
    for (int r = 0; r < NREG; r++) c += int'(m_busy[r]);
    return c;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NRS; i++) begin
        logic [AW-1:0] a;
        a = rs_addr[i*AW +: AW];
        check($sformatf("rd_byp[%0d]", i), 64'(rs_data_b[i*XLEN +: XLEN]), 64'(exp_read(a, 1'b1)));
        check($sformatf("rd_nobyp[%0d]", i), 64'(rs_data_n[i*XLEN +: XLEN]), 64'(exp_read(a, 1'b0)));
        check($sformatf("busy_b[%0d]", i), 64'(rs_busy_b[i]), 64'(m_busy[a]));
        check($sformatf("busy_n[%0d]", i), 64'(rs_busy_n[i]), 64'(m_busy[a]));
      end
      check("rsv_ok_b", 64'(rsv_ok_b), 64'(rsv_req && (rsv_addr == 0 || !m_busy[rsv_addr])));
      check("rsv_ok_n", 64'(rsv_ok_n), 64'(rsv_req && (rsv_addr == 0 || !m_busy[rsv_addr])));
      check("busy_cnt_b", 64'(busy_cnt_b), 64'(exp_cnt()));
      check("busy_cnt_n", 64'(busy_cnt_n), 64'(exp_cnt()));
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_data = '0; wr_release = '0;
    rsv_req = 1'b0; rsv_addr = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int p, input logic [AW-1:0] a);
    rs_addr[p*AW +: AW] = a;
  endtask

  task automatic set_wr(input int p, input logic [AW-1:0] a, input logic [XLEN-1:0] d, input bit rel);
    wr_en[p] = 1'b1;
    wr_addr[p*AW +: AW] = a;
    wr_data[p*XLEN +: XLEN] = d;
    wr_release[p] = rel;
  endtask

  initial begin
    rst = 1'b0;
    rs_addr = '0;
    idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    chk_en = 1'b1;

    // 1: all registers zero, nothing busy
    for (int a = 0; a < NREG; a++) begin
      set_rd(0, AW'(a));
      set_rd(1, AW'(31 - a));
      #2 check("t1_rd", 64'(rs_data_b[XLEN-1:0]), 64'h0);
      tick();
    end
    check("t1_cnt", 64'(busy_cnt_b), 64'h0);

    // 2: bypass visibility
    set_wr(0, 5'd5, 32'hDEADBEEF, 1'b0);
    set_rd(0, 5'd5);
    #2 check("t2_byp_same", 64'(rs_data_b[XLEN-1:0]), 64'hDEADBEEF);
    check("t2_nobyp_same", 64'(rs_data_n[XLEN-1:0]), 64'h0);
    tick();
    idle();
    #2 check("t2_nobyp_next", 64'(rs_data_n[XLEN-1:0]), 64'hDEADBEEF);
    tick();

    // 3: both write ports hit reg7, port 1 wins
    set_wr(0, 5'd7, 32'h1111, 1'b0);
    set_wr(1, 5'd7, 32'h2222, 1'b0);
    set_rd(1, 5'd7);
    #2 check("t3_byp_same", 64'(rs_data_b[2*XLEN-1:XLEN]), 64'h2222);
    tick();
    idle();
    #2 check("t3_next_b", 64'(rs_data_b[2*XLEN-1:XLEN]), 64'h2222);
    check("t3_next_n", 64'(rs_data_n[2*XLEN-1:XLEN]), 64'h2222);
    tick();

    // 4: reserve reg3, re-reserve, release racing a reserve
    rsv_req = 1'b1; rsv_addr = 5'd3;
    set_rd(1, 5'd3);
    #2 check("t4_ok", 64'(rsv_ok_b), 64'h1);
    check("t4_busy_before", 64'(rs_busy_b[1]), 64'h0);
    tick();
    #2 check("t4_busy", 64'(rs_busy_b[1]), 64'h1);
    check("t4_reok", 64'(rsv_ok_b), 64'h0);
    check("t4_cnt", 64'(busy_cnt_b), 64'h1);
    tick();
    set_wr(0, 5'd3, 32'h0ABC, 1'b1);
    #2 check("t4_race_ok", 64'(rsv_ok_n), 64'h0);
    tick();
    idle();
    #2 check("t4_race_busy", 64'(rs_busy_n[1]), 64'h1);
    check("t4_race_cnt", 64'(busy_cnt_n), 64'h1);
    check("t4_race_data", 64'(rs_data_n[2*XLEN-1:XLEN]), 64'h0ABC);
    set_wr(0, 5'd3, 32'h0DEF, 1'b1);
    tick();
    idle();
    #2 check("t4_rel_cnt", 64'(busy_cnt_b), 64'h0);
    check("t4_rel_busy", 64'(rs_busy_b[1]), 64'h0);
    // releasing a free register changes nothing
    set_wr(1, 5'd9, 32'h99, 1'b1);
    tick();
    idle();
    #2 check("t4_noop_cnt", 64'(busy_cnt_b), 64'h0);

    // 5: register 0 is immune
    set_wr(0, 5'd0, 32'hFFFF_FFFF, 1'b0);
    rsv_req = 1'b1; rsv_addr = 5'd0;
    set_rd(0, 5'd0);
    #2 check("t5_ok", 64'(rsv_ok_b), 64'h1);
    check("t5_rd_same", 64'(rs_data_b[XLEN-1:0]), 64'h0);
    tick();
    idle();
    #2 check("t5_rd", 64'(rs_data_b[XLEN-1:0]), 64'h0);
    check("t5_busy", 64'(rs_busy_b[0]), 64'h0);
    check("t5_cnt", 64'(busy_cnt_b), 64'h0);

    // 6: reserve 1..4, then async reset mid-cycle
    for (int r = 1; r <= 4; r++) begin
      rsv_req = 1'b1; rsv_addr = AW'(r);
      set_wr(1, AW'(r + 10), 32'h100 + r, 1'b0);
      tick();
    end
    idle();
    set_rd(0, 5'd11);
    set_rd(1, 5'd5);
    #2 check("t6_cnt4", 64'(busy_cnt_b), 64'h4);
    check("t6_pre_rd", 64'(rs_data_n[XLEN-1:0]), 64'h101);
    // a write and a reserve in flight when reset hits are discarded
    set_wr(0, 5'd6, 32'h5A5A, 1'b0);
    rsv_req = 1'b1; rsv_addr = 5'd6;
    #1 rst = 1'b0;
    #1 check("t6_cnt0", 64'(busy_cnt_b), 64'h0);
    check("t6_cnt0_n", 64'(busy_cnt_n), 64'h0);
    check("t6_rd11", 64'(rs_data_n[XLEN-1:0]), 64'h0);
    check("t6_rd5", 64'(rs_data_n[2*XLEN-1:XLEN]), 64'h0);
    tick();
    idle();
    #1 rst = 1'b1;
    set_rd(0, 5'd6);
    tick();
    #2 check("t6_rd6", 64'(rs_data_b[XLEN-1:0]), 64'h0);
    check("t6_busy6", 64'(rs_busy_b[0]), 64'h0);
    tick();
    tick();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
